// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU issue sequencer: ALUOp codes, RV32I funct3
// codes and the sequencer state type.
package alu_seq_pkg;

    // ALUOp codes understood by the external combinational ALU
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SRL  = 3'b100;
    localparam logic [2:0] ALU_SRA  = 3'b101;
    localparam logic [2:0] ALU_SLT  = 3'b110;
    localparam logic [2:0] ALU_SLTU = 3'b111;

    // RV32I OP / OP-IMM funct3 codes
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        XOR_OR,
        XOR_AND,
        XOR_SUB,
        SLL_LOOP,
        DONE
    } state_t;

endpackage

// File: rtl/alu_seq.sv
// Multi-cycle issue sequencer in front of the external 3-bit-ALUOp ALU.
// Single-pass ops take one EXEC cycle; XOR is built as (A|B)-(A&B) and
// SLL as repeated A+A, both over several ALU passes.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic            in_f7b5,
    input  logic            in_is_imm,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [4:0]      in_rd,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_op,
    input  logic [XLEN-1:0] alu_c,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            busy
);

    state_t            state, state_next;
    logic [XLEN-1:0]   a_q, b_q, tmp, tmp2, acc;
    logic [2:0]        op_q;
    logic [SHW-1:0]    cnt;

    logic [XLEN-1:0]   b_sel, b_shamt, dec_b;
    logic [2:0]        dec_op;
    state_t            dec_state;

    // Decode the incoming instruction into ALUOp, operand B and first state
    always_comb begin
        b_sel     = in_is_imm ? in_imm : in_rs2;
        b_shamt   = {{(XLEN-SHW){1'b0}}, b_sel[SHW-1:0]};
        dec_b     = b_sel;
        dec_op    = ALU_ADD;
        dec_state = EXEC;
        case (in_funct3)
            F3_ADD:  dec_op = (!in_is_imm && in_f7b5) ? ALU_SUB : ALU_ADD;
            F3_SLL: begin
                // A zero shift degenerates to A + 0 through a plain EXEC pass
                dec_b  = b_shamt;
                dec_op = ALU_ADD;
                if (b_shamt != '0) dec_state = SLL_LOOP;
            end
            F3_SLT:  dec_op = ALU_SLT;
            F3_SLTU: dec_op = ALU_SLTU;
            F3_XOR:  dec_state = XOR_OR;
            F3_SR: begin
                dec_b  = b_shamt;
                dec_op = in_f7b5 ? ALU_SRA : ALU_SRL;
            end
            F3_OR:   dec_op = ALU_OR;
            F3_AND:  dec_op = ALU_AND;
            default: dec_op = ALU_ADD;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic and ALU drive / handshake outputs
    always_comb begin
        state_next = state;
        alu_a      = '0;
        alu_b      = '0;
        alu_op     = ALU_ADD;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = dec_state;
            end
            EXEC: begin
                alu_a      = a_q;
                alu_b      = b_q;
                alu_op     = op_q;
                state_next = DONE;
            end
            XOR_OR: begin
                alu_a      = a_q;
                alu_b      = b_q;
                alu_op     = ALU_OR;
                state_next = XOR_AND;
            end
            XOR_AND: begin
                alu_a      = a_q;
                alu_b      = b_q;
                alu_op     = ALU_AND;
                state_next = XOR_SUB;
            end
            XOR_SUB: begin
                alu_a      = tmp;
                alu_b      = tmp2;
                alu_op     = ALU_SUB;
                state_next = DONE;
            end
            SLL_LOOP: begin
                alu_a  = acc;
                alu_b  = acc;
                alu_op = ALU_ADD;
                if (cnt == SHW'(1)) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Operand capture and per-pass result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= ALU_ADD;
            tmp        <= '0;
            tmp2       <= '0;
            acc        <= '0;
            cnt        <= '0;
            out_result <= '0;
            out_rd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= in_rs1;
                        b_q    <= dec_b;
                        op_q   <= dec_op;
                        out_rd <= in_rd;
                        acc    <= in_rs1;
                        cnt    <= dec_b[SHW-1:0];
                    end
                end
                EXEC:    out_result <= alu_c;
                XOR_OR:  tmp        <= alu_c;
                XOR_AND: tmp2       <= alu_c;
                XOR_SUB: out_result <= alu_c;
                SLL_LOOP: begin
                    acc <= alu_c;
                    cnt <= cnt - 1'b1;
                    if (cnt == SHW'(1)) out_result <= alu_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural model of the external ALU.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = '0;
    logic        in_f7b5 = 1'b0;
    logic        in_is_imm = 1'b0;
    logic [31:0] in_rs1 = '0, in_rs2 = '0, in_imm = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [2:0]  alu_op;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        busy;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [2:0]  op_hist [0:3];
    logic [31:0] b_first;

    always #5 clk = ~clk;

    alu_seq #(.XLEN(32), .SHW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct3(in_funct3), .in_f7b5(in_f7b5), .in_is_imm(in_is_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .busy(busy)
    );

    // External combinational ALU
    always_comb begin
        case (alu_op)
            3'b000:  alu_c = alu_a + alu_b;
            3'b001:  alu_c = alu_a - alu_b;
            3'b010:  alu_c = alu_a & alu_b;
            3'b011:  alu_c = alu_a | alu_b;
            3'b100:  alu_c = alu_a >> alu_b[4:0];
            3'b101:  alu_c = $unsigned($signed(alu_a) >>> alu_b[4:0]);
            3'b110:  alu_c = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_c = {31'd0, alu_a < alu_b};
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Issue one instruction, wait for the result, hold off out_ready for
    // 'hold' cycles checking stability, then complete the handshake.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic f7,
                          input logic imm_sel, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_lat,
                          input logic [2:0] exp_op0, input logic [31:0] exp_b0,
                          input int hold);
        int lat;
        @(negedge clk);
        in_funct3 = f3; in_f7b5 = f7; in_is_imm = imm_sel;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_rd = rd;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_rs1 = $urandom; in_rs2 = $urandom; in_imm = $urandom;
        in_rd = 5'(~rd); in_funct3 = 3'(~f3);
        lat = 1;
        op_hist[0] = alu_op;
        b_first = alu_b;
        check({tag, "_op0"}, {29'd0, alu_op}, {29'd0, exp_op0});
        check({tag, "_b0"}, alu_b, exp_b0);
        check({tag, "_in_ready_busy"}, {30'd0, in_ready, busy}, 32'd1);
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (!out_valid && lat <= 4) op_hist[lat-1] = alu_op;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, out_result, exp_res);
        check({tag, "_rd"}, {27'd0, out_rd}, {27'd0, rd});
        check({tag, "_done_alu"}, {alu_a | alu_b, 29'd0} | {29'd0, alu_op}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid_ready"}, {30'd0, out_valid, in_ready}, 32'd2);
            check({tag, "_hold_result"}, out_result, exp_res);
            check({tag, "_hold_rd"}, {27'd0, out_rd}, {27'd0, rd});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_after_handshake"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        #12;
        check("reset_ready_valid_busy", {29'd0, in_ready, out_valid, busy}, 32'd4);
        check("reset_result", out_result, 32'd0);
        check("reset_rd", {27'd0, out_rd}, 32'd0);
        check("reset_alu", alu_a | alu_b | {29'd0, alu_op}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op("add",  3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3,
               32'd12, 2, 3'b000, 32'd7, 0);
        run_op("sub",  3'b000, 1'b1, 1'b0, 32'd3, 32'd5, 32'd0, 5'd4,
               32'hFFFF_FFFE, 2, 3'b001, 32'd5, 0);
        run_op("addi", 3'b000, 1'b1, 1'b1, 32'd3, 32'd99, 32'd5, 5'd5,
               32'd8, 2, 3'b000, 32'd5, 0);
        run_op("xor",  3'b100, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 5'd6,
               32'h0FF0_0FF0, 4, 3'b011, 32'hFF00_FF00, 0);
        check("xor_op1", {29'd0, op_hist[1]}, 32'd2);
        check("xor_op2", {29'd0, op_hist[2]}, 32'd1);
        run_op("sll31", 3'b001, 1'b0, 1'b0, 32'd1, 32'd31, 32'd0, 5'd7,
               32'h8000_0000, 32, 3'b000, 32'd1, 0);
        check("sll31_op2", {29'd0, op_hist[2]}, 32'd0);
        run_op("sll_mask", 3'b001, 1'b0, 1'b0, 32'd1, 32'h25, 32'd0, 5'd8,
               32'h20, 6, 3'b000, 32'd1, 0);
        run_op("sll0", 3'b001, 1'b0, 1'b0, 32'h1234, 32'd0, 32'd0, 5'd9,
               32'h1234, 2, 3'b000, 32'd0, 0);
        run_op("slli3", 3'b001, 1'b0, 1'b1, 32'h3, 32'd0, 32'd3, 5'd10,
               32'h18, 4, 3'b000, 32'd3, 0);
        run_op("sra",  3'b101, 1'b1, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 5'd11,
               32'hF800_0000, 2, 3'b101, 32'd4, 0);
        run_op("srl_mask", 3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'h24, 32'd0, 5'd12,
               32'h0800_0000, 2, 3'b100, 32'd4, 0);
        run_op("slt",  3'b010, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 5'd13,
               32'd1, 2, 3'b110, 32'd4, 0);
        run_op("sltu", 3'b011, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 5'd14,
               32'd0, 2, 3'b111, 32'd4, 0);
        run_op("ori",  3'b110, 1'b0, 1'b1, 32'h0000_00F0, 32'd0, 32'h0000_000F, 5'd15,
               32'h0000_00FF, 2, 3'b011, 32'h0000_000F, 0);
        run_op("and_bp", 3'b111, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 5'd16,
               32'h0000_F000, 2, 3'b010, 32'h0000_FF00, 3);

        // Reset in the middle of a long shift drops the instruction
        @(negedge clk);
        in_funct3 = 3'b001; in_f7b5 = 1'b0; in_is_imm = 1'b0;
        in_rs1 = 32'd1; in_rs2 = 32'd31; in_rd = 5'd20;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
        check("rst_mid_alu", alu_a | alu_b | {29'd0, alu_op}, 32'd0);
        check("rst_mid_result", out_result, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("rst_no_valid", seen, 32'd0);
        run_op("add_after_rst", 3'b000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 5'd21,
               32'd1, 2, 3'b000, 32'd2, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "timeout");
    end

endmodule
